iota_round_seq: RTL

// - Keccak-f[1600] iota stage and round sequencer for SHA3-256. Takes lane A[0,0] after chi,

---
 rtl/iota_round_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/iota_round_seq.sv
// -----------------------------------------------------------------------------
// iota_round_seq
//   Keccak-f[1600] iota stage plus round sequencer for SHA3-256.
//   Takes lane A[0,0] after chi, XORs in the round constant expanded from the
//   external rc generator's 7 bits, and registers the result (latency 1).
//   Also strobes the rc generator (rc_rst / rc_en, both registered) and
//   counts rounds 0..ROUNDS-1, re-initialising the generator on the wrap.
//
// Configuration macro:
//   IOTA_ABORT_EN  adds input in_abort; a high in_abort at a clock edge
//                  restarts the permutation and drops any lane offered in
//                  that cycle. Without it only rst_n restarts a permutation.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_lane    in   W   lane A[0,0] from chi
//   in_valid   in   1   in_lane valid
//   in_ready   out  1   stage accepts in_lane this cycle
//   in_abort   in   1   restart permutation (only with IOTA_ABORT_EN)
//   out_lane   out  W   in_lane ^ expanded RC, registered
//   out_valid  out  1   out_lane valid
//   out_ready  in   1   consumer accepts out_lane
//   out_round  out  5   round index of out_lane
//   out_last   out  1   out_lane belongs to round ROUNDS-1
//   rc_bits    in   7   rc generator output {rc6..rc0} for the current round
//   rc_rst     out  1   to rc generator rst
//   rc_en      out  1   to rc generator en
// -----------------------------------------------------------------------------
module iota_round_seq #(
    parameter int unsigned W      = 64,
    parameter int unsigned ROUNDS = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_lane,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef IOTA_ABORT_EN
    input  logic         in_abort,
`endif
    output logic [W-1:0] out_lane,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_round,
    output logic         out_last,
    input  logic [6:0]   rc_bits,
    output logic         rc_rst,
    output logic         rc_en
);

    localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        StInitLo,
        StInitHi,
        StReady,
        StAdvHi,
        StAdvLo
    } state_e;

    state_e     state_q;
    logic [4:0] round_q;

    logic         abort;
    logic         xfer;
    logic [63:0]  rc_exp64;
    logic [W-1:0] rc_exp;

`ifdef IOTA_ABORT_EN
    assign abort = in_abort;
`else
    assign abort = 1'b0;
`endif

    // rc bit j lands on lane bit 2^j-1: positions 0,1,3,7,15,31,63.
    assign rc_exp64 = {rc_bits[6], 31'b0, rc_bits[5], 15'b0, rc_bits[4], 7'b0,
                       rc_bits[3], 3'b0, rc_bits[2], 1'b0, rc_bits[1], rc_bits[0]};
    assign rc_exp   = rc_exp64[W-1:0];

    // rc_bits only matter in StReady, where rc_en has been low for a full cycle.
    assign in_ready = (state_q == StReady) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInitLo;
            round_q   <= '0;
            rc_rst    <= 1'b1;
            rc_en     <= 1'b0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (abort) begin
            // Abort wins over a simultaneous transfer; the offered lane is dropped.
            state_q   <= StInitLo;
            round_q   <= '0;
            rc_rst    <= 1'b1;
            rc_en     <= 1'b0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else begin
            // Output register: load on transfer (also covers drain+accept in one
            // cycle), clear when drained, otherwise hold.
            if (xfer) begin
                out_lane  <= in_lane ^ rc_exp;
                out_round <= round_q;
                out_last  <= (round_q == LastRound);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_lane  <= '0;
                out_round <= '0;
                out_last  <= 1'b0;
                out_valid <= 1'b0;
            end

            unique case (state_q)
                StInitLo: begin
                    state_q <= StInitHi;
                    rc_rst  <= 1'b1;
                    rc_en   <= 1'b1;
                end
                StInitHi: begin
                    state_q <= StReady;
                    rc_rst  <= 1'b0;
                    rc_en   <= 1'b0;
                end
                StReady: begin
                    if (xfer) begin
                        if (round_q == LastRound) begin
                            // Permutation done: reload rc instead of advancing it.
                            state_q <= StInitLo;
                            round_q <= '0;
                            rc_rst  <= 1'b1;
                            rc_en   <= 1'b0;
                        end else begin
                            state_q <= StAdvHi;
                            round_q <= round_q + 5'd1;
                            rc_rst  <= 1'b0;
                            rc_en   <= 1'b1;
                        end
                    end
                end
                StAdvHi: begin
                    state_q <= StAdvLo;
                    rc_en   <= 1'b0;
                end
                StAdvLo: begin
                    // Settle cycle so rc_bits are stable before the next accept.
                    state_q <= StReady;
                end
                default: begin
                    state_q <= StInitLo;
                    rc_rst  <= 1'b1;
                    rc_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule
